issue_scoreboard: RTL and testbench

- Issue controller between decode and execute.
- Tracks in-flight destination registers and in-flight instruction count, and decides each cycle whether the decoded instruction may issue.
- Generates the decode/fetch stall and serialises ecall: drains the pipeline, then holds the front end until the environment call completes.
- Branch squash from EX cancels the instruction currently in decode.

---
 rtl/issue_pkg.sv | 18 +
 rtl/issue_scoreboard_if.sv | 41 ++++
 rtl/issue_scoreboard_busy_table.sv | 49 ++++
 rtl/issue_scoreboard.sv | 114 +++++++++++
 tb/tb_issue_scoreboard.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_pkg.sv
// Shared types and constants for the issue scoreboard.
package issue_pkg;

    localparam int unsigned NREGS        = 32;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned MAX_INFLIGHT = 8;
    localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ECALL = 2'd2
    } issue_state_t;

    localparam logic [REG_W-1:0] REG_X0    = 5'd0;
    localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode / writeback / environment signals seen by the issue scoreboard.
interface issue_scoreboard_if;
    import issue_pkg::*;

    logic                   id_valid;
    logic [REG_W-1:0]       id_rs1reg;
    logic [REG_W-1:0]       id_rs2reg;
    logic                   id_uses_rs1;
    logic                   id_uses_rs2;
    logic [REG_W-1:0]       id_rd;
    logic                   id_writes_rd;
    logic                   id_is_ecall;
    logic                   EXIF_branch;
    logic                   wb_retire;
    logic                   wb_wen;
    logic [REG_W-1:0]       wb_rd;
    logic                   ecalldone;

    logic                   id_issue;
    logic                   IDIF_stall;
    logic                   ecall_req;
    logic [NREGS-1:0]       busy_mask;
    logic [CNT_W-1:0]       inflight_cnt;

    // Pipeline side: drives decode/writeback/environment, observes decisions.
    modport master (
        output id_valid, id_rs1reg, id_rs2reg, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, id_is_ecall, EXIF_branch,
               wb_retire, wb_wen, wb_rd, ecalldone,
        input  id_issue, IDIF_stall, ecall_req, busy_mask, inflight_cnt
    );

    // Scoreboard side.
    modport slave (
        input  id_valid, id_rs1reg, id_rs2reg, id_uses_rs1, id_uses_rs2,
               id_rd, id_writes_rd, id_is_ecall, EXIF_branch,
               wb_retire, wb_wen, wb_rd, ecalldone,
        output id_issue, IDIF_stall, ecall_req, busy_mask, inflight_cnt
    );

endinterface

// File: rtl/issue_scoreboard_busy_table.sv
// Pending-write bit per architectural register; x0 is never marked busy.
module issue_scoreboard_busy_table
    import issue_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_set_en,
    input  logic [REG_W-1:0]   i_set_idx,
    input  logic               i_clr_en,
    input  logic [REG_W-1:0]   i_clr_idx,
    input  logic [REG_W-1:0]   i_rs1,
    input  logic [REG_W-1:0]   i_rs2,
    input  logic [REG_W-1:0]   i_rd,
    output logic               o_busy_rs1_c,
    output logic               o_busy_rs2_c,
    output logic               o_busy_rd_c,
    output logic [NREGS-1:0]   o_mask
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;

    // Clear first so a coincident set of the same index wins.
    always_comb begin
        w_busy_next = r_busy;
        if (i_clr_en && (i_clr_idx != REG_X0)) begin
            w_busy_next[i_clr_idx] = 1'b0;
        end
        if (i_set_en && (i_set_idx != REG_X0)) begin
            w_busy_next[i_set_idx] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // Busy bit register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy_rs1_c = r_busy[i_rs1];
    assign o_busy_rs2_c = r_busy[i_rs2];
    assign o_busy_rd_c  = r_busy[i_rd];
    assign o_mask       = r_busy;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller: hazard check, in-flight count and ecall serialisation.
module issue_scoreboard
    import issue_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    issue_scoreboard_if.slave  bus
);

    issue_state_t       r_state;
    issue_state_t       w_state_next;
    logic [CNT_W-1:0]   r_inflight_cnt;
    logic [CNT_W-1:0]   w_inflight_cnt_next;
    logic               r_ecall_req;
    logic               w_busy_rs1;
    logic               w_busy_rs2;
    logic               w_busy_rd;
    logic [NREGS-1:0]   w_busy_mask;
    logic               w_raw;
    logic               w_waw;
    logic               w_full;
    logic               w_issue;
    logic               w_stall;

    issue_scoreboard_busy_table u_busy_table (
        .clk          (clk),
        .reset        (reset),
        .i_set_en     (w_issue & bus.id_writes_rd),
        .i_set_idx    (bus.id_rd),
        .i_clr_en     (bus.wb_retire & bus.wb_wen),
        .i_clr_idx    (bus.wb_rd),
        .i_rs1        (bus.id_rs1reg),
        .i_rs2        (bus.id_rs2reg),
        .i_rd         (bus.id_rd),
        .o_busy_rs1_c (w_busy_rs1),
        .o_busy_rs2_c (w_busy_rs2),
        .o_busy_rd_c  (w_busy_rd),
        .o_mask       (w_busy_mask)
    );

    // Hazards look only at registered state, so a same-cycle writeback does not bypass.
    assign w_raw  = (bus.id_uses_rs1 & w_busy_rs1) | (bus.id_uses_rs2 & w_busy_rs2);
    assign w_waw  = bus.id_writes_rd & w_busy_rd;
    assign w_full = (r_inflight_cnt == CNT_W'(MAX_INFLIGHT));

    // Next-state and issue/stall decisions.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_stall      = 1'b0;
        unique case (r_state)
            RUN: begin
                w_issue = bus.id_valid & ~bus.EXIF_branch & ~w_raw & ~w_waw
                        & ~w_full & ~bus.id_is_ecall;
                w_stall = bus.id_valid & ~bus.EXIF_branch & ~w_issue;
                if (bus.id_valid && bus.id_is_ecall && !bus.EXIF_branch) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_stall = 1'b1;
                if (bus.EXIF_branch) begin
                    w_state_next = RUN;
                end else if ((r_inflight_cnt == '0) && (w_busy_mask == '0)) begin
                    w_state_next = ECALL;
                end
            end
            ECALL: begin
                w_stall = 1'b1;
                if (bus.ecalldone) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    // In-flight count; a retire with nothing in flight leaves it at zero.
    always_comb begin
        w_inflight_cnt_next = r_inflight_cnt;
        if (w_issue && !bus.wb_retire) begin
            w_inflight_cnt_next = r_inflight_cnt + CNT_W'(1);
        end else if (!w_issue && bus.wb_retire && (r_inflight_cnt != '0)) begin
            w_inflight_cnt_next = r_inflight_cnt - CNT_W'(1);
        end
    end

    // State, counter and ecall request registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= RUN;
            r_inflight_cnt <= '0;
            r_ecall_req    <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_inflight_cnt <= w_inflight_cnt_next;
            r_ecall_req    <= (w_state_next == ECALL);
        end
    end

    a_no_retire_when_empty: assert property (
        @(posedge clk) disable iff (!reset)
        !(bus.wb_retire && (r_inflight_cnt == '0))
    );

    assign bus.id_issue     = w_issue;
    assign bus.IDIF_stall   = w_stall;
    assign bus.ecall_req    = r_ecall_req;
    assign bus.busy_mask    = w_busy_mask;
    assign bus.inflight_cnt = r_inflight_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios plus random traffic against an in-order queue model.
module tb_issue_scoreboard;
    import issue_pkg::*;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_ECALL = 2;

    typedef struct {
        bit         valid;
        bit         u1;
        bit         u2;
        bit         wr;
        bit         ec;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_t;

    typedef struct {
        logic [4:0] rd;
        bit         w;
    } flight_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    issue_scoreboard_if bus ();

    issue_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int      n_checks = 0;
    int      n_errors = 0;
    flight_t q[$];
    int      m_mode;
    dec_t    d;
    bit      last_issue;
    bit      last_stall;
    bit      consumed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_busy(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].w && q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i].w && q[i].rd != 5'd0) m[q[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic set_dec(input dec_t x);
        d = x;
        bus.id_valid     = x.valid;
        bus.id_uses_rs1  = x.u1;
        bus.id_uses_rs2  = x.u2;
        bus.id_writes_rd = x.wr;
        bus.id_is_ecall  = x.ec;
        bus.id_rs1reg    = x.rs1;
        bus.id_rs2reg    = x.rs2;
        bus.id_rd        = x.rd;
    endtask

    task automatic instr(input bit u1, input int rs1, input bit u2, input int rs2,
                         input bit wr, input int rd, input bit ec);
        dec_t x;
        x.valid = 1'b1; x.u1 = u1; x.u2 = u2; x.wr = wr; x.ec = ec;
        x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.rd = 5'(rd);
        set_dec(x);
    endtask

    task automatic idle_dec();
        dec_t x;
        x = '{default: '0};
        set_dec(x);
    endtask

    // Decode replaces a completed ecall with the canonical NOP (addi x0,x0,0).
    task automatic load_nop();
        logic [31:0] w;
        w = NOP_INSTR;
        instr(1'b1, int'(w[19:15]), 1'b0, 0, 1'b1, int'(w[11:7]), 1'b0);
    endtask

    task automatic random_dec();
        dec_t x;
        x.valid = ($urandom_range(0, 7) != 0);
        x.u1    = $urandom_range(0, 1) != 0;
        x.u2    = $urandom_range(0, 1) != 0;
        x.wr    = $urandom_range(0, 3) != 0;
        x.ec    = ($urandom_range(0, 19) == 0);
        x.rs1   = 5'($urandom_range(0, 7));
        x.rs2   = 5'($urandom_range(0, 7));
        x.rd    = 5'($urandom_range(0, 7));
        set_dec(x);
    endtask

    task automatic do_reset();
        idle_dec();
        bus.EXIF_branch = 1'b0;
        bus.wb_retire   = 1'b0;
        bus.wb_wen      = 1'b0;
        bus.wb_rd       = 5'd0;
        bus.ecalldone   = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        q.delete();
        m_mode = M_RUN;
        check("rst_busy_mask", bus.busy_mask, 32'h0);
        check("rst_inflight_cnt", 32'(bus.inflight_cnt), 32'h0);
        check("rst_ecall_req", 32'(bus.ecall_req), 32'h0);
        reset = 1'b1;
    endtask

    // One clock: drive, check combinational decisions at negedge, check registered state after the edge.
    task automatic cycle(input bit br, input bit ret, input bit edone);
        bit do_ret;
        bit e_issue;
        bit e_stall;
        bit hz;
        int mode_before;
        int size_before;
        do_ret = ret && (q.size() > 0);
        bus.EXIF_branch = br;
        bus.wb_retire   = do_ret;
        bus.wb_wen      = 1'b0;
        bus.wb_rd       = 5'd0;
        if (do_ret) begin
            bus.wb_wen = q[0].w;
            bus.wb_rd  = q[0].rd;
        end
        bus.ecalldone = edone;
        @(negedge clk);
        e_issue = 1'b0;
        e_stall = 1'b1;
        if (m_mode == M_RUN) begin
            hz = (d.u1 && is_busy(d.rs1)) || (d.u2 && is_busy(d.rs2)) ||
                 (d.wr && is_busy(d.rd)) || (q.size() >= MAX_INFLIGHT);
            e_issue = d.valid && !br && !hz && !d.ec;
            e_stall = d.valid && !br && !e_issue;
        end
        check("id_issue", 32'(bus.id_issue), 32'(e_issue));
        check("IDIF_stall", 32'(bus.IDIF_stall), 32'(e_stall));
        mode_before = m_mode;
        size_before = q.size();
        @(posedge clk); #1;
        if (do_ret) void'(q.pop_front());
        if (e_issue) q.push_back('{rd: d.rd, w: d.wr});
        case (mode_before)
            M_RUN:   if (d.valid && d.ec && !br) m_mode = M_DRAIN;
            M_DRAIN: if (br) m_mode = M_RUN; else if (size_before == 0) m_mode = M_ECALL;
            default: if (edone) m_mode = M_RUN;
        endcase
        last_issue = e_issue;
        last_stall = e_stall;
        consumed   = e_issue || (br && mode_before != M_ECALL) ||
                     (mode_before == M_ECALL && edone);
        check("busy_mask", bus.busy_mask, model_mask());
        check("inflight_cnt", 32'(bus.inflight_cnt), 32'(q.size()));
        check("ecall_req", 32'(bus.ecall_req), 32'(m_mode == M_ECALL));
        bus.EXIF_branch = 1'b0;
        bus.wb_retire   = 1'b0;
        bus.wb_wen      = 1'b0;
        bus.wb_rd       = 5'd0;
        bus.ecalldone   = 1'b0;
    endtask

    initial begin
        m_mode = M_RUN;
        do_reset();
        cycle(0, 0, 0);
        check("idle_no_issue", 32'(last_issue), 32'h0);

        // Dependent pair: add x5,x1,x2 then addi x6,x5,1.
        instr(1, 1, 1, 2, 1, 5, 0);
        cycle(0, 0, 0);
        check("dep_first_issue", 32'(last_issue), 32'h1);
        check("dep_mask_x5", bus.busy_mask, 32'h20);
        instr(1, 5, 0, 0, 1, 6, 0);
        cycle(0, 0, 0);
        check("dep_stall", 32'(last_stall), 32'h1);
        cycle(0, 1, 0);
        check("dep_no_bypass", 32'(last_issue), 32'h0);
        cycle(0, 0, 0);
        check("dep_issue_after_wb", 32'(last_issue), 32'h1);
        check("dep_mask_x6", bus.busy_mask, 32'h40);

        // x0 destination is never tracked.
        do_reset();
        instr(1, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0);
        check("x0_mask", bus.busy_mask, 32'h0);
        instr(1, 0, 1, 0, 1, 7, 0);
        cycle(0, 0, 0);
        check("x0_reader_issue", 32'(last_issue), 32'h1);

        // Fill to MAX_INFLIGHT, ninth stalls until one retires.
        do_reset();
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            instr(0, 0, 0, 0, 0, 0, 0);
            cycle(0, 0, 0);
        end
        check("full_cnt", 32'(bus.inflight_cnt), 32'(MAX_INFLIGHT));
        cycle(0, 0, 0);
        check("full_ninth_stall", 32'(last_stall), 32'h1);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        check("full_ninth_issue", 32'(last_issue), 32'h1);
        check("full_cnt_after", 32'(bus.inflight_cnt), 32'(MAX_INFLIGHT));

        // Ecall waits for two in-flight instructions to drain.
        do_reset();
        instr(0, 0, 0, 0, 1, 3, 0); cycle(0, 0, 0);
        instr(0, 0, 0, 0, 1, 4, 0); cycle(0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0);
        check("ecall_not_issued", 32'(last_issue), 32'h0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        check("ecall_wait_drain", 32'(bus.ecall_req), 32'h0);
        cycle(0, 0, 0);
        check("ecall_req_set", 32'(bus.ecall_req), 32'h1);
        cycle(1, 0, 0);
        check("ecall_branch_ignored", 32'(bus.ecall_req), 32'h1);
        cycle(0, 0, 1);
        check("ecall_req_clear", 32'(bus.ecall_req), 32'h0);
        instr(1, 3, 1, 4, 1, 9, 0);
        cycle(0, 0, 0);
        check("post_ecall_issue", 32'(last_issue), 32'h1);

        // Branch squashes an ecall waiting in DRAIN.
        do_reset();
        instr(0, 0, 0, 0, 1, 2, 0); cycle(0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 1); cycle(0, 0, 0);
        cycle(1, 0, 0);
        check("squash_no_issue", 32'(last_issue), 32'h0);
        idle_dec();
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        check("squash_no_ecall_req", 32'(bus.ecall_req), 32'h0);

        // Reset while ECALL is active.
        do_reset();
        instr(1, 1, 0, 0, 1, 8, 0); cycle(0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 1); cycle(0, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        check("pre_reset_ecall", 32'(bus.ecall_req), 32'h1);
        do_reset();
        instr(1, 8, 0, 0, 1, 8, 0);
        cycle(0, 0, 0);
        check("reset_back_to_run", 32'(last_issue), 32'h1);

        // Random traffic.
        do_reset();
        random_dec();
        for (int n = 0; n < 4000; n++) begin
            bit br;
            bit edone;
            int mode_before;
            mode_before = m_mode;
            br    = ($urandom_range(0, 15) == 0);
            edone = (m_mode == M_ECALL) && ($urandom_range(0, 3) == 0);
            cycle(br, $urandom_range(0, 2) == 0, edone);
            if (mode_before == M_ECALL && edone) load_nop();
            else if (consumed || !d.valid) random_dec();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
